// File: rtl/stack_store_monitor.sv
// +--------------------------------------------------------------------------+
// | stack_store_monitor: flags non-frame stores that overwrite recently      |
// | frame-stored (sp/fp-relative) windows in a protected region.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module stack_store_monitor #(
    parameter int         DEPTH      = 6,
    parameter int         AW         = 32,
    parameter int         WIN_LOG2   = 2,
    parameter logic [3:0] REGION_TAG = 4'h8,
    parameter int         CNT_W      = 8,
    localparam int        OCC_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             st_valid_i,
    input  logic [AW-1:0]    st_addr_i,
    input  logic [1:0]       st_size_i,
    input  logic             st_frame_i,
    input  logic             flush_i,
    input  logic             alert_clr_i,
    output logic             alert_o,
    output logic [AW-1:0]    alert_addr_o,
    output logic             alert_sticky_o,
    output logic [CNT_W-1:0] viol_cnt_o,
    output logic [OCC_W-1:0] occupancy_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [AW-1:0]    WIN_MASK = ~((AW'(1) << WIN_LOG2) - AW'(1));
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    // Windows are kept as masked byte addresses; the constant low bits prune away.
    logic [DEPTH-1:0] valid;
    logic [AW-1:0]    win_tbl [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] count;

    logic          accepted;
    logic          frame_wr;
    logic          viol;
    logic          hit_s;
    logic          hit_e;
    logic [AW-1:0] span;
    logic [AW-1:0] end_addr;
    logic [AW-1:0] win_s;
    logic [AW-1:0] win_e;

    always_comb begin
        accepted = st_valid_i & en_i & ~flush_i & (st_addr_i[AW-1:AW-4] == REGION_TAG);
        case (st_size_i)
            2'd0:    span = AW'(0);
            2'd1:    span = AW'(1);
            default: span = AW'(3);
        endcase
        end_addr = st_addr_i + span;
        win_s    = st_addr_i & WIN_MASK;
        win_e    = end_addr & WIN_MASK;
        hit_s    = 1'b0;
        hit_e    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (win_tbl[i] == win_s)) hit_s = 1'b1;
            if (valid[i] && (win_tbl[i] == win_e)) hit_e = 1'b1;
        end
        frame_wr = accepted & st_frame_i & ~hit_s;
        viol     = accepted & ~st_frame_i & (hit_s | hit_e);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid  <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) win_tbl[i] <= '0;
        end else if (flush_i) begin
            valid  <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (frame_wr) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ptr == PTR_W'(i)) begin
                    win_tbl[i] <= win_s;
                    valid[i]   <= 1'b1;
                end
            end
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            count  <= (count == OCC_FULL) ? count : count + OCC_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alert_o        <= 1'b0;
            alert_addr_o   <= '0;
            alert_sticky_o <= 1'b0;
            viol_cnt_o     <= '0;
        end else begin
            alert_o <= viol;
            if (viol) alert_addr_o <= st_addr_i;
            // A new violation takes priority over a coincident clear.
            if (viol)             alert_sticky_o <= 1'b1;
            else if (alert_clr_i) alert_sticky_o <= 1'b0;
            if (viol && !(&viol_cnt_o)) viol_cnt_o <= viol_cnt_o + CNT_W'(1);
        end
    end

    assign occupancy_o = count;

endmodule

`default_nettype wire

// File: tb/tb_stack_store_monitor.sv
// +--------------------------------------------------------------------------+
// | tb_stack_store_monitor: scoreboard bench with a queue-based table model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_stack_store_monitor;

    localparam int DEPTH = 6;
    localparam int CNT_W = 2;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             st_valid = 1'b0;
    logic [31:0]      st_addr = '0;
    logic [1:0]       st_size = '0;
    logic             st_frame = 1'b0;
    logic             flush = 1'b0;
    logic             alert_clr = 1'b0;
    logic             alert;
    logic [31:0]      alert_addr;
    logic             alert_sticky;
    logic [CNT_W-1:0] viol_cnt;
    logic [OCC_W-1:0] occupancy;

    stack_store_monitor #(
        .DEPTH(DEPTH), .AW(32), .WIN_LOG2(2), .REGION_TAG(4'h8), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .st_valid_i(st_valid),
        .st_addr_i(st_addr), .st_size_i(st_size), .st_frame_i(st_frame),
        .flush_i(flush), .alert_clr_i(alert_clr), .alert_o(alert),
        .alert_addr_o(alert_addr), .alert_sticky_o(alert_sticky),
        .viol_cnt_o(viol_cnt), .occupancy_o(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        alert;
        logic [31:0] addr;
        logic        sticky;
        int          cnt;
        int          occ;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    // Reference model: windows (address >> 2) in insertion order, oldest first.
    logic [29:0] m_tbl[$];
    logic [31:0] m_addr;
    logic        m_sticky;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit in_tbl(input logic [29:0] w);
        foreach (m_tbl[i]) if (m_tbl[i] == w) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_tbl.delete();
        m_addr   = '0;
        m_sticky = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [1:0] sz,
                         input logic fr, input logic e, input logic fl, input logic clr);
        logic [31:0] nbytes;
        logic [31:0] last;
        logic [29:0] ws;
        logic [29:0] we;
        logic        acc;
        logic        hit;
        exp_t        x;
        @(negedge clk);
        st_valid = v; st_addr = a; st_size = sz; st_frame = fr;
        en = e; flush = fl; alert_clr = clr;
        nbytes = (sz == 2'd0) ? 32'd1 : (sz == 2'd1) ? 32'd2 : 32'd4;
        last   = a + nbytes - 32'd1;
        ws     = a[31:2];
        we     = last[31:2];
        acc    = v && e && !fl && (a[31:28] == 4'h8);
        hit    = 1'b0;
        if (acc && fr) begin
            if (!in_tbl(ws)) begin
                if (m_tbl.size() == DEPTH) void'(m_tbl.pop_front());
                m_tbl.push_back(ws);
            end
        end else if (acc) begin
            hit = in_tbl(ws) || in_tbl(we);
        end
        if (fl) m_tbl.delete();
        if (hit) begin
            m_addr   = a;
            m_sticky = 1'b1;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else if (clr) begin
            m_sticky = 1'b0;
        end
        x.alert = hit; x.addr = m_addr; x.sticky = m_sticky;
        x.cnt = m_cnt; x.occ = m_tbl.size();
        exp_q.push_back(x);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic fstore(input logic [31:0] a, input logic [1:0] sz);
        drive(1'b1, a, sz, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic nstore(input logic [31:0] a, input logic [1:0] sz);
        drive(1'b1, a, sz, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_alert"},  32'(alert), 32'd0);
        chk({tag, "_addr"},   alert_addr, 32'd0);
        chk({tag, "_sticky"}, 32'(alert_sticky), 32'd0);
        chk({tag, "_cnt"},    32'(viol_cnt), 32'd0);
        chk({tag, "_occ"},    32'(occupancy), 32'd0);
    endtask

    // Asynchronous reset pulse placed entirely between two rising edges.
    task automatic async_reset();
        @(negedge clk);
        st_valid = 1'b1; st_addr = 32'h8000_0000; st_frame = 1'b1; flush = 1'b0;
        #1 rst = 1'b1;
        #1 check_zero("async_rst");
        st_valid = 1'b0;
        #1 rst = 1'b0;
        model_reset();
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("alert",    32'(alert),        32'(mon_e.alert));
            chk("addr",     alert_addr,        mon_e.addr);
            chk("sticky",   32'(alert_sticky), 32'(mon_e.sticky));
            chk("viol_cnt", 32'(viol_cnt),     32'(mon_e.cnt));
            chk("occ",      32'(occupancy),    32'(mon_e.occ));
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Basic hit, then same-window byte store.
        fstore(32'h8000_1000, 2'd2);
        nstore(32'h8000_1000, 2'd2);
        idle();
        nstore(32'h8000_1003, 2'd0);
        idle();

        // Misaligned word spanning into a recorded window; aligned half does not.
        fstore(32'h8000_2004, 2'd2);
        nstore(32'h8000_2002, 2'd2);
        nstore(32'h8000_2000, 2'd1);
        idle();

        // Wrap-around: seven distinct windows into six entries.
        drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) fstore(32'h8000_0000 + 32'(i * 4), 2'd2);
        nstore(32'h8000_0000, 2'd2);
        nstore(32'h8000_0018, 2'd2);
        idle();

        // Duplicates, foreign region, disabled monitoring.
        drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        fstore(32'h8000_3000, 2'd2);
        fstore(32'h8000_3000, 2'd2);
        nstore(32'h4000_3000, 2'd2);
        drive(1'b1, 32'h8000_4000, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h8000_3000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        // Flush colliding with a hit; clear colliding with a new violation.
        drive(1'b1, 32'h8000_3000, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        fstore(32'h8000_3000, 2'd2);
        drive(1'b1, 32'h8000_3000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Counter saturation.
        for (int i = 0; i < 5; i++) nstore(32'h8000_3001, 2'd0);
        idle();

        async_reset();
        idle();

        // Randomised traffic concentrated on a small address range.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            a = {($urandom_range(0, 9) == 0) ? 4'h4 : 4'h8, 28'h0} | 32'($urandom_range(0, 47));
            if ($urandom_range(0, 49) == 0) a = 32'h8FFF_FFFC | 32'($urandom_range(0, 3));
            drive($urandom_range(0, 4) != 0, a, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
            if (i == 300) begin
                async_reset();
                idle();
            end
        end
        idle();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
